// File: rtl/rx_ram_arbiter.sv
// Two-master Avalon-MM arbiter in front of the single-port packet RAM.
// Ports: m0_*/m1_* master ports, ram_* slave port, arb_timeout, grant_owner.
module rx_ram_arbiter #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1,
    parameter int RX_PRIORITY  = 1,
    parameter int TIMEOUT      = 255
) (
    input  logic                clk_original,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic                m0_chipselect,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_waitrequest,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic                m1_chipselect,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_waitrequest,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic                ram_chipselect,
    output logic                ram_write,
    output logic [DATA_W-1:0]   ram_writedata,
    output logic [DATA_W/8-1:0] ram_byteenable,
    input  logic [DATA_W-1:0]   ram_readdata,
    input  logic                ram_waitrequest,
    output logic                arb_timeout,
    output logic                grant_owner
);

    localparam logic [9:0] TO_LAST = 10'(TIMEOUT - 1);
    localparam logic [2:0] LAT_INIT =
        3'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);
    localparam logic [DATA_W-1:0] ABORT_DATA = DATA_W'(32'hDEAD_BEEF);

    typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT, DONE} state_t;

    state_t      state;
    logic        grant;
    logic        last_grant;
    logic [9:0]  wait_cnt;
    logic [2:0]  lat_cnt;

    logic              req_any;
    logic              winner;
    logic              finish;
    logic              load_rd;
    logic [DATA_W-1:0] load_val;

    // finish: this edge moves the FSM into DONE.
    // load_rd: the granted master's readdata register is written on that edge.
    always_comb begin
        req_any  = m0_chipselect | m1_chipselect;
        winner   = m1_chipselect;
        if (m0_chipselect && m1_chipselect)
            winner = (RX_PRIORITY != 0) ? 1'b0 : ~last_grant;
        finish   = 1'b0;
        load_rd  = 1'b0;
        load_val = ram_readdata;
        unique case (state)
            ACCESS: begin
                if (ram_waitrequest) begin
                    // Hung slave: abort with a recognisable pattern
                    finish   = (wait_cnt == TO_LAST);
                    load_rd  = finish;
                    load_val = ABORT_DATA;
                end else begin
                    finish  = ram_write || (READ_LATENCY == 0);
                    load_rd = !ram_write && (READ_LATENCY == 0);
                end
            end
            RDWAIT: begin
                finish  = (lat_cnt == 3'd0);
                load_rd = finish;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_original) begin
        if (rst) begin
            state          <= IDLE;
            grant          <= 1'b1;
            last_grant     <= 1'b1;
            wait_cnt       <= '0;
            lat_cnt        <= '0;
            ram_addr       <= '0;
            ram_chipselect <= 1'b0;
            ram_write      <= 1'b0;
            ram_writedata  <= '0;
            ram_byteenable <= '0;
            m0_waitrequest <= 1'b1;
            m1_waitrequest <= 1'b1;
            m0_readdata    <= '0;
            m1_readdata    <= '0;
            arb_timeout    <= 1'b0;
        end else begin
            arb_timeout <= 1'b0;
            if (finish) begin
                state          <= DONE;
                ram_chipselect <= 1'b0;
                if (grant) m1_waitrequest <= 1'b0;
                else       m0_waitrequest <= 1'b0;
                if (load_rd) begin
                    if (grant) m1_readdata <= load_val;
                    else       m0_readdata <= load_val;
                end
                if (state == ACCESS && ram_waitrequest)
                    arb_timeout <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (req_any) begin
                            ram_addr       <= winner ? m1_addr : m0_addr;
                            ram_write      <= winner ? m1_write : m0_write;
                            ram_writedata  <= winner ? m1_writedata
                                                     : m0_writedata;
                            ram_byteenable <= winner ? m1_byteenable
                                                     : m0_byteenable;
                            ram_chipselect <= 1'b1;
                            grant          <= winner;
                            wait_cnt       <= '0;
                            state          <= ACCESS;
                        end
                    end
                    ACCESS: begin
                        // Not finishing here means stalled, or an
                        // accepted read that still has latency to cover
                        if (ram_waitrequest) begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end else begin
                            ram_chipselect <= 1'b0;
                            lat_cnt        <= LAT_INIT;
                            state          <= RDWAIT;
                        end
                    end
                    RDWAIT: lat_cnt <= lat_cnt - 1'b1;
                    DONE: begin
                        m0_waitrequest <= 1'b1;
                        m1_waitrequest <= 1'b1;
                        last_grant     <= grant;
                        state          <= IDLE;
                    end
                endcase
            end
        end
    end

    assign grant_owner = (state == IDLE) ? last_grant : grant;

endmodule

// File: tb/tb_rx_ram_arbiter.sv
// Self-checking bench for rx_ram_arbiter with a scoreboard of completions.
// Main DUT: round-robin, TIMEOUT=4; second DUT: RX priority, zero-wait RAM.
module tb_rx_ram_arbiter;

    logic        clk;
    logic        rst;
    logic [9:0]  m0_addr, m1_addr;
    logic        m0_chipselect, m1_chipselect;
    logic        m0_write, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [9:0]  ram_addr;
    logic        ram_chipselect, ram_write;
    logic [31:0] ram_writedata;
    logic [3:0]  ram_byteenable;
    logic [31:0] ram_readdata;
    logic        ram_waitrequest;
    logic        arb_timeout, grant_owner;

    logic [31:0] p_m0_readdata, p_m1_readdata;
    logic        p_m0_waitrequest, p_m1_waitrequest;
    logic [9:0]  p_ram_addr;
    logic        p_ram_chipselect, p_ram_write;
    logic [31:0] p_ram_writedata;
    logic [3:0]  p_ram_byteenable;
    logic [31:0] p_ram_readdata;
    logic        p_ram_waitrequest;
    logic        p_arb_timeout, p_grant_owner;

    logic [31:0] rd_value;

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit          who;
        bit          rd;
        logic [31:0] data;
        int          n;
    } exp_t;

    typedef struct {
        int          n;
        int          csn;
        int          ton;
        bit          who;
        logic [31:0] rdata;
        logic [31:0] oth;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        wr;
        logic        owner;
    } obs_t;

    exp_t exp_q[$];

    rx_ram_arbiter #(
        .ADDR_W(10), .DATA_W(32), .READ_LATENCY(1),
        .RX_PRIORITY(0), .TIMEOUT(4)
    ) dut (
        .clk_original(clk), .rst(rst),
        .m0_addr(m0_addr), .m0_chipselect(m0_chipselect),
        .m0_write(m0_write), .m0_writedata(m0_writedata),
        .m0_byteenable(m0_byteenable), .m0_readdata(m0_readdata),
        .m0_waitrequest(m0_waitrequest),
        .m1_addr(m1_addr), .m1_chipselect(m1_chipselect),
        .m1_write(m1_write), .m1_writedata(m1_writedata),
        .m1_byteenable(m1_byteenable), .m1_readdata(m1_readdata),
        .m1_waitrequest(m1_waitrequest),
        .ram_addr(ram_addr), .ram_chipselect(ram_chipselect),
        .ram_write(ram_write), .ram_writedata(ram_writedata),
        .ram_byteenable(ram_byteenable), .ram_readdata(ram_readdata),
        .ram_waitrequest(ram_waitrequest),
        .arb_timeout(arb_timeout), .grant_owner(grant_owner)
    );

    rx_ram_arbiter #(
        .ADDR_W(10), .DATA_W(32), .READ_LATENCY(1),
        .RX_PRIORITY(1), .TIMEOUT(4)
    ) dut_pri (
        .clk_original(clk), .rst(rst),
        .m0_addr(m0_addr), .m0_chipselect(m0_chipselect),
        .m0_write(m0_write), .m0_writedata(m0_writedata),
        .m0_byteenable(m0_byteenable), .m0_readdata(p_m0_readdata),
        .m0_waitrequest(p_m0_waitrequest),
        .m1_addr(m1_addr), .m1_chipselect(m1_chipselect),
        .m1_write(m1_write), .m1_writedata(m1_writedata),
        .m1_byteenable(m1_byteenable), .m1_readdata(p_m1_readdata),
        .m1_waitrequest(p_m1_waitrequest),
        .ram_addr(p_ram_addr), .ram_chipselect(p_ram_chipselect),
        .ram_write(p_ram_write), .ram_writedata(p_ram_writedata),
        .ram_byteenable(p_ram_byteenable), .ram_readdata(p_ram_readdata),
        .ram_waitrequest(p_ram_waitrequest),
        .arb_timeout(p_arb_timeout), .grant_owner(p_grant_owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign p_ram_readdata    = 32'h0;
    assign p_ram_waitrequest = 1'b0;

    // RAM model: read data valid only in the cycle after the accept edge
    always @(posedge clk) begin
        if (ram_chipselect && !ram_waitrequest && !ram_write)
            ram_readdata <= rd_value;
        else
            ram_readdata <= 32'hBAD0_0000;
    end

    // Waits for the DUT DONE cycle; RAM stalls stall_n accept attempts.
    task automatic wait_done(input int stall_n, output obs_t o);
        bit snapped = 0;
        o = '{default: 0};
        o.n = -1;
        ram_waitrequest = (stall_n != 0);
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (ram_chipselect) begin
                o.csn++;
                if (!snapped) begin
                    snapped = 1;
                    o.addr  = ram_addr;
                    o.wdata = ram_writedata;
                    o.be    = ram_byteenable;
                    o.wr    = ram_write;
                    o.owner = grant_owner;
                end
            end
            if (arb_timeout) o.ton++;
            if (o.csn > stall_n) ram_waitrequest = 1'b0;
            if (!m0_waitrequest || !m1_waitrequest) begin
                o.n     = i;
                o.who   = m0_waitrequest;
                o.rdata = o.who ? m1_readdata : m0_readdata;
                o.oth   = o.who ? m0_readdata : m1_readdata;
                break;
            end
        end
        ram_waitrequest = 1'b0;
    endtask

    task automatic idle_masters();
        m0_chipselect = 0;
        m1_chipselect = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        tests++;
        if ({ram_chipselect, ram_write, ram_addr, ram_writedata,
             ram_byteenable} !== '0) begin
            fails++;
            $display("FAIL reset_ram: got cs=%b addr=%h wd=%h be=%h need 0",
                     ram_chipselect, ram_addr, ram_writedata, ram_byteenable);
        end
        tests++;
        if ({m0_waitrequest, m1_waitrequest} !== 2'b11) begin
            fails++;
            $display("FAIL reset_wait: got %b%b need 11",
                     m0_waitrequest, m1_waitrequest);
        end
        tests++;
        if ({m0_readdata, m1_readdata} !== 64'h0) begin
            fails++;
            $display("FAIL reset_rdata: got %h %h need 0",
                     m0_readdata, m1_readdata);
        end
        tests++;
        if (arb_timeout !== 1'b0) begin
            fails++;
            $display("FAIL reset_timeout: got %b need 0", arb_timeout);
        end
        tests++;
        if (grant_owner !== 1'b1) begin
            fails++;
            $display("FAIL reset_owner: got %b need 1", grant_owner);
        end
    endtask

    task automatic test_write();
        obs_t o;
        exp_t e;
        exp_q.push_back('{who: 0, rd: 0, data: 0, n: 2});
        m0_addr = 10'h005; m0_write = 1;
        m0_writedata = 32'h1122_3344; m0_byteenable = 4'hF;
        m0_chipselect = 1;
        wait_done(0, o);
        idle_masters();
        e = exp_q.pop_front();
        tests++;
        if (o.who !== e.who || o.n !== e.n) begin
            fails++;
            $display("FAIL wr_done: got who=%0d cyc=%0d need who=%0d cyc=%0d",
                     o.who, o.n, e.who, e.n);
        end
        tests++;
        if (o.csn !== 1) begin
            fails++;
            $display("FAIL wr_cs_cycles: got %0d need 1", o.csn);
        end
        tests++;
        if (o.addr !== 10'h005 || o.wr !== 1'b1) begin
            fails++;
            $display("FAIL wr_addr: got %h/%b need 005/1", o.addr, o.wr);
        end
        tests++;
        if (o.wdata !== 32'h1122_3344 || o.be !== 4'hF) begin
            fails++;
            $display("FAIL wr_data: got %h/%h need 11223344/f",
                     o.wdata, o.be);
        end
        tests++;
        if (o.owner !== 1'b0) begin
            fails++;
            $display("FAIL wr_owner: got %b need 0", o.owner);
        end
    endtask

    task automatic test_read(input int stall, input logic [9:0] a,
                             input logic [31:0] v, input logic [31:0] m0_keep);
        obs_t o;
        exp_t e;
        exp_q.push_back('{who: 1, rd: 1, data: v, n: 3 + stall});
        rd_value = v;
        m1_addr = a; m1_write = 0;
        m1_writedata = 32'h0; m1_byteenable = 4'hF;
        m1_chipselect = 1;
        wait_done(stall, o);
        idle_masters();
        e = exp_q.pop_front();
        tests++;
        if (o.who !== e.who || o.n !== e.n) begin
            fails++;
            $display("FAIL rd_done_s%0d: got who=%0d cyc=%0d need who=%0d cyc=%0d",
                     stall, o.who, o.n, e.who, e.n);
        end
        tests++;
        if (e.rd && o.rdata !== e.data) begin
            fails++;
            $display("FAIL rd_data_s%0d: got %h need %h",
                     stall, o.rdata, e.data);
        end
        tests++;
        if (o.oth !== m0_keep) begin
            fails++;
            $display("FAIL rd_m0_kept_s%0d: got %h need %h",
                     stall, o.oth, m0_keep);
        end
        tests++;
        if (o.addr !== a || o.wr !== 1'b0 || o.csn !== stall + 1) begin
            fails++;
            $display("FAIL rd_access_s%0d: got addr=%h wr=%b cs=%0d need %h 0 %0d",
                     stall, o.addr, o.wr, o.csn, a, stall + 1);
        end
    endtask

    task automatic test_timeout(input logic [31:0] m1_keep);
        obs_t o;
        exp_t e;
        exp_q.push_back('{who: 0, rd: 1, data: 32'hDEAD_BEEF, n: 5});
        rd_value = 32'h5555_AAAA;
        m0_addr = 10'h010; m0_write = 0; m0_chipselect = 1;
        wait_done(1000, o);
        idle_masters();
        e = exp_q.pop_front();
        tests++;
        if (o.who !== e.who || o.n !== e.n) begin
            fails++;
            $display("FAIL to_done: got who=%0d cyc=%0d need who=%0d cyc=%0d",
                     o.who, o.n, e.who, e.n);
        end
        tests++;
        if (o.rdata !== e.data) begin
            fails++;
            $display("FAIL to_data: got %h need %h", o.rdata, e.data);
        end
        tests++;
        if (o.csn !== 4) begin
            fails++;
            $display("FAIL to_cs_cycles: got %0d need 4", o.csn);
        end
        tests++;
        if (o.ton !== 1 || arb_timeout !== 1'b0) begin
            fails++;
            $display("FAIL to_pulse: got %0d pulses, now %b need 1, 0",
                     o.ton, arb_timeout);
        end
        tests++;
        if (o.oth !== m1_keep) begin
            fails++;
            $display("FAIL to_m1_kept: got %h need %h", o.oth, m1_keep);
        end
    endtask

    task automatic test_priority();
        int ga[$];
        int gb[$];
        int qa[$];
        int qb[$];
        rst = 1;
        @(negedge clk);
        rst = 0;
        qa = '{0, 1, 0, 1};
        qb = '{0, 0, 0, 0};
        m0_addr = 10'h001; m0_write = 1; m0_writedata = 32'hA0A0_A0A0;
        m1_addr = 10'h002; m1_write = 1; m1_writedata = 32'hB1B1_B1B1;
        m0_byteenable = 4'hF; m1_byteenable = 4'hF;
        m0_chipselect = 1; m1_chipselect = 1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!m0_waitrequest)   ga.push_back(0);
            if (!m1_waitrequest)   ga.push_back(1);
            if (!p_m0_waitrequest) gb.push_back(0);
            if (!p_m1_waitrequest) gb.push_back(1);
            if (ga.size() >= 4 && gb.size() >= 4) break;
        end
        idle_masters();
        for (int k = 0; k < 4; k++) begin
            int a;
            int b;
            int ea;
            int eb;
            a  = (k < ga.size()) ? ga[k] : -1;
            b  = (k < gb.size()) ? gb[k] : -1;
            ea = qa.pop_front();
            eb = qb.pop_front();
            tests++;
            if (a !== ea) begin
                fails++;
                $display("FAIL rr_grant%0d: got m%0d need m%0d", k, a, ea);
            end
            tests++;
            if (b !== eb) begin
                fails++;
                $display("FAIL prio_grant%0d: got m%0d need m%0d", k, b, eb);
            end
        end
    endtask

    task automatic test_reset_rdwait();
        obs_t o;
        exp_t e;
        bit early = 0;
        rd_value = 32'h7777_8888;
        m1_addr = 10'h0F0; m1_write = 0; m1_chipselect = 1;
        ram_waitrequest = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1;
        m1_chipselect = 0;
        @(negedge clk);
        tests++;
        if (ram_chipselect !== 1'b0 ||
            {m0_waitrequest, m1_waitrequest} !== 2'b11) begin
            fails++;
            $display("FAIL rst_mid: got cs=%b wait=%b%b need 0 11",
                     ram_chipselect, m0_waitrequest, m1_waitrequest);
        end
        tests++;
        if (m1_readdata !== 32'h0 || grant_owner !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid_regs: got rd=%h owner=%b need 0 1",
                     m1_readdata, grant_owner);
        end
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (!m0_waitrequest || !m1_waitrequest) early = 1;
        end
        tests++;
        if (early) begin
            fails++;
            $display("FAIL rst_no_done: got a DONE cycle need none");
        end
        exp_q.push_back('{who: 0, rd: 0, data: 0, n: 2});
        m0_addr = 10'h020; m0_write = 1; m1_addr = 10'h021; m1_write = 1;
        m0_chipselect = 1; m1_chipselect = 1;
        wait_done(0, o);
        idle_masters();
        e = exp_q.pop_front();
        tests++;
        if (o.who !== e.who || o.n !== e.n) begin
            fails++;
            $display("FAIL rst_tie: got who=%0d cyc=%0d need who=%0d cyc=%0d",
                     o.who, o.n, e.who, e.n);
        end
    endtask

    initial begin
        rst = 1;
        rd_value = 0;
        ram_waitrequest = 0;
        m0_addr = 0; m0_chipselect = 0; m0_write = 0;
        m0_writedata = 0; m0_byteenable = 0;
        m1_addr = 0; m1_chipselect = 0; m1_write = 0;
        m1_writedata = 0; m1_byteenable = 0;
        test_reset();
        test_write();
        test_read(0, 10'h3FF, 32'hCAFE_F00D, 32'h0);
        test_read(3, 10'h0AA, 32'h1234_5678, 32'h0);
        test_timeout(32'h1234_5678);
        test_priority();
        test_reset_rdwait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish need finish");
        $fatal(1, "watchdog");
    end

endmodule
